// File: rtl/iob2axi_pkg.sv
// Shared definitions for the native-to-AXI4 bridge.
// FSM state encodings and fixed AXI attribute codes.
package iob2axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [3:0] AXI_CACHE      = 4'b0011;
  localparam logic [2:0] AXI_PROT       = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic resp_is_err(
    input logic [1:0] resp
  );
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob_native_to_axi.sv
// Single-beat bridge from the native valid/ready bus to an AXI4 master.
// Define IOB2AXI_RESP_ERR_EN to latch non-OKAY responses into err.
module iob_native_to_axi
  import iob2axi_pkg::*;
#(
  parameter int   ADDR_W = 24,
  parameter int   DATA_W = 32,
  parameter logic AXI_ID = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic [0:0]          axi_awid,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic                axi_awlock,
  output logic [3:0]          axi_awcache,
  output logic [2:0]          axi_awprot,
  output logic [3:0]          axi_awqos,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wlast,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [0:0]          axi_bid,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic [0:0]          axi_arid,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  output logic                axi_arlock,
  output logic [3:0]          axi_arcache,
  output logic [2:0]          axi_arprot,
  output logic [3:0]          axi_arqos,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [0:0]          axi_rid,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  input  logic                axi_rvalid,
  output logic                axi_rready
);

  state_t state, state_nxt;

  logic [ADDR_W-3:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_q, w_q, ar_q;
  logic                ready_q;

  logic take, is_write;
  logic aw_hs, w_hs, ar_hs;
  logic aw_done, w_done;
  logic b_fire, r_fire;

  // The ready cycle itself never starts a new request.
  assign take     = valid & ~ready_q;
  assign is_write = |wstrb;

  assign aw_hs   = aw_q & axi_awready;
  assign w_hs    = w_q & axi_wready;
  assign ar_hs   = ar_q & axi_arready;
  assign aw_done = ~aw_q | aw_hs;
  assign w_done  = ~w_q | w_hs;

  assign axi_bready = (state == S_WRESP);
  assign axi_rready = (state == S_RDATA);
  assign b_fire     = axi_bvalid & axi_bready;
  assign r_fire     = axi_rvalid & axi_rready;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (take) state_nxt = is_write ? S_WRITE : S_RADDR;
      S_WRITE:
        if (aw_done && w_done) state_nxt = S_WRESP;
      S_WRESP:
        if (axi_bvalid) state_nxt = S_IDLE;
      S_RADDR:
        if (ar_hs) state_nxt = S_RDATA;
      S_RDATA:
        if (axi_rvalid) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      ar_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (state == S_IDLE && take) begin
        addr_q  <= addr[ADDR_W-1:2];
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        aw_q    <= is_write;
        w_q     <= is_write;
        ar_q    <= ~is_write;
      end
      if (aw_hs) aw_q <= 1'b0;
      if (w_hs)  w_q  <= 1'b0;
      if (ar_hs) ar_q <= 1'b0;
      if (r_fire) rdata_q <= axi_rdata;
      ready_q <= b_fire | r_fire;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = {addr_q, 2'b00};
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = AXI_SIZE_4B;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = AXI_CACHE;
  assign axi_awprot  = AXI_PROT;
  assign axi_awqos   = 4'd0;
  assign axi_awvalid = aw_q;

  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_wlast  = 1'b1;
  assign axi_wvalid = w_q;

  assign axi_arid    = AXI_ID;
  assign axi_araddr  = {addr_q, 2'b00};
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = AXI_SIZE_4B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = AXI_CACHE;
  assign axi_arprot  = AXI_PROT;
  assign axi_arqos   = 4'd0;
  assign axi_arvalid = ar_q;

  logic unused;

`ifdef IOB2AXI_RESP_ERR_EN
  logic err_q;

  // Sticky until reset; the transaction itself still completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((b_fire && resp_is_err(axi_bresp)) ||
                 (r_fire && resp_is_err(axi_rresp))) begin
      err_q <= 1'b1;
    end
  end

  assign err    = err_q;
  assign unused = ^{addr[1:0], axi_bid, axi_rid, axi_rlast};
`else
  assign err    = 1'b0;
  assign unused = ^{addr[1:0], axi_bid, axi_rid, axi_rlast,
                    axi_bresp, axi_rresp};
`endif

endmodule

// File: tb/tb_iob_native_to_axi.sv
// Directed and randomized checks of iob_native_to_axi against a
// reactive AXI slave model and a word-array memory reference.
module tb_iob_native_to_axi;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

`ifdef IOB2AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [31:0]       rdata;
  logic              ready, err;

  logic [0:0]        axi_awid, axi_arid;
  logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
  logic [7:0]        axi_awlen, axi_arlen;
  logic [2:0]        axi_awsize, axi_arsize, axi_awprot, axi_arprot;
  logic [1:0]        axi_awburst, axi_arburst;
  logic              axi_awlock, axi_arlock;
  logic [3:0]        axi_awcache, axi_arcache, axi_awqos, axi_arqos;
  logic              axi_awvalid, axi_wvalid, axi_arvalid;
  logic              axi_bready, axi_rready, axi_wlast;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_awready = 1'b0, axi_wready = 1'b0;
  logic              axi_arready = 1'b0;
  logic              axi_bvalid = 1'b0, axi_rvalid = 1'b0;
  logic [1:0]        axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic [31:0]       axi_rdata = '0;
  logic [0:0]        axi_bid = 1'b0, axi_rid = 1'b0;
  logic              axi_rlast = 1'b1;

  iob_native_to_axi #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .err(err),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave knobs: *_len = cycles a valid stays up before accepted
  int   aw_len = 1, w_len = 1, ar_len = 1;
  int   b_gap = 0, r_gap = 0;
  bit   r_never = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [31:0] smem [64];
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int n_ready = 0, aw_hi = 0, w_hi = 0;
  logic [ADDR_W-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit aw_got, w_got, b_pend, ar_got;
    bit aw_stall, w_stall, ar_stall;
    int aw_run, w_run, ar_run, bwait, rwait;
    logic [ADDR_W-1:0] aw_prev, ar_prev;
    {hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
    {aw_got, w_got, b_pend, ar_got} = '0;
    {aw_stall, w_stall, ar_stall} = '0;
    {aw_run, w_run, ar_run, bwait, rwait} = '0;
    aw_prev = '0;
    ar_prev = '0;
    for (int i = 0; i < 64; i++) smem[i] = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        {hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
        {aw_got, w_got, b_pend, ar_got} = '0;
        {aw_stall, w_stall, ar_stall} = '0;
        {aw_run, w_run, ar_run} = '0;
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        axi_arready = 1'b0;
        axi_bvalid = 1'b0;
        axi_rvalid = 1'b0;
        continue;
      end
      if (ready) n_ready++;
      if (axi_awvalid) aw_hi++;
      if (axi_wvalid) w_hi++;
      if (aw_stall)
        chk("aw_hold", {axi_awvalid, axi_awaddr}, {1'b1, aw_prev});
      if (ar_stall)
        chk("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, ar_prev});
      if (w_stall) chk("w_hold", axi_wvalid, 1'b1);
      if (hs_b) begin axi_bvalid = 1'b0; n_b++; end
      if (hs_r) begin axi_rvalid = 1'b0; n_r++; end
      if (hs_aw) aw_got = 1'b1;
      if (hs_w) w_got = 1'b1;
      if (hs_ar) begin ar_got = 1'b1; rwait = r_gap; end
      if (aw_got && w_got) begin
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i])
            smem[cap_awaddr[7:2]][8*i +: 8] = cap_wdata[8*i +: 8];
        aw_got = 1'b0;
        w_got = 1'b0;
        b_pend = 1'b1;
        bwait = b_gap;
      end
      if (b_pend && !axi_bvalid) begin
        if (bwait == 0) begin
          axi_bvalid = 1'b1;
          axi_bresp = bresp_cfg;
          b_pend = 1'b0;
        end else bwait--;
      end
      if (ar_got && !r_never && !axi_rvalid) begin
        if (rwait == 0) begin
          axi_rvalid = 1'b1;
          axi_rdata = smem[cap_araddr[7:2]];
          axi_rresp = rresp_cfg;
          ar_got = 1'b0;
        end else rwait--;
      end
      aw_run = axi_awvalid ? aw_run + 1 : 0;
      w_run  = axi_wvalid ? w_run + 1 : 0;
      ar_run = axi_arvalid ? ar_run + 1 : 0;
      axi_awready = axi_awvalid && aw_run >= aw_len;
      axi_wready  = axi_wvalid && w_run >= w_len;
      axi_arready = axi_arvalid && ar_run >= ar_len;
      hs_aw = axi_awvalid && axi_awready;
      hs_w  = axi_wvalid && axi_wready;
      hs_ar = axi_arvalid && axi_arready;
      hs_b  = axi_bvalid && axi_bready;
      hs_r  = axi_rvalid && axi_rready;
      if (hs_aw) begin cap_awaddr = axi_awaddr; n_aw++; end
      if (hs_ar) begin cap_araddr = axi_araddr; n_ar++; end
      if (hs_w) begin
        cap_wdata = axi_wdata;
        cap_wstrb = axi_wstrb;
        n_w++;
        chk("wlast", axi_wlast, 1'b1);
      end
      aw_stall = axi_awvalid && !axi_awready;
      w_stall  = axi_wvalid && !axi_wready;
      ar_stall = axi_arvalid && !axi_arready;
      aw_prev  = axi_awaddr;
      ar_prev  = axi_araddr;
    end
  end

  logic [31:0] model [64];
  bit exp_err = 1'b0;

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[7:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Called at a negedge; returns at the negedge where ready is seen
  // (hold=1) or one cycle later after checking ready fell (hold=0).
  task automatic req(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit hold,
                     output logic [31:0] rd, output int lat);
    addr = a;
    wdata = d;
    wstrb = s;
    valid = 1'b1;
    lat = 1;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ready !== 1'b1) begin
        addr = ADDR_W'($urandom);
        wdata = $urandom;
        wstrb = 4'($urandom);
      end
    end
    chk("ready_seen", ready, 1'b1);
    rd = rdata;
    if (!hold) begin
      valid = 1'b0;
      @(negedge clk);
      chk("ready_pulse", ready, 1'b0);
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int lat, na, nr, nrdy, cyc;
    for (int i = 0; i < 64; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_outs",
        {ready, axi_awvalid, axi_wvalid, axi_arvalid,
         axi_bready, axi_rready, err},
        7'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("aw_const",
        {axi_awlen, axi_awsize, axi_awburst, axi_awlock,
         axi_awcache, axi_awprot, axi_awqos, axi_awid},
        {8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'h0, 1'b0});
    chk("ar_const",
        {axi_arlen, axi_arsize, axi_arburst, axi_arlock,
         axi_arcache, axi_arprot, axi_arqos, axi_arid},
        {8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'h0, 1'b0});
    reset = 1'b1;
    @(negedge clk);

    na = n_aw;
    req(24'h000104, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat);
    model_write(24'h000104, 32'hDEADBEEF, 4'hF);
    chk("wr_latency", lat, 4);
    chk("wr_awaddr", cap_awaddr, 24'h000104);
    chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", cap_wstrb, 4'hF);
    chk("wr_one_aw", n_aw - na, 1);

    req(24'h000106, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("rd_latency", lat, 4);
    chk("rd_araddr", cap_araddr, 24'h000104);
    chk("rd_data", rd, model[6'h01]);

    aw_len = 3;
    aw_hi = 0;
    w_hi = 0;
    nrdy = n_ready;
    req(24'h000020, 32'h12345678, 4'h5, 1'b0, rd, lat);
    model_write(24'h000020, 32'h12345678, 4'h5);
    repeat (3) @(negedge clk);
    chk("awdly_aw_cycles", aw_hi, 3);
    chk("awdly_w_cycles", w_hi, 1);
    chk("awdly_one_ready", n_ready - nrdy, 1);
    aw_len = 1;
    w_len = 3;
    req(24'h000020, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("awdly_readback", rd, model[6'h08]);
    w_len = 1;

    bresp_cfg = 2'b10;
    req(24'h000030, 32'hA5A5A5A5, 4'hF, 1'b0, rd, lat);
    model_write(24'h000030, 32'hA5A5A5A5, 4'hF);
    exp_err = ERR_EN;
    chk("bresp_err", err, exp_err);
    bresp_cfg = 2'b00;
    req(24'h000034, 32'h0BADF00D, 4'hF, 1'b0, rd, lat);
    model_write(24'h000034, 32'h0BADF00D, 4'hF);
    req(24'h000030, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("err_sticky", err, exp_err);
    chk("err_rd_data", rd, model[6'h0C]);

    r_never = 1'b1;
    addr = 24'h000034;
    wstrb = 4'h0;
    valid = 1'b1;
    cyc = 0;
    while (axi_rready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rdata_state_reached", axi_rready, 1'b1);
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("midrst_outs",
        {axi_rready, ready, axi_arvalid, axi_awvalid, axi_bready},
        5'b0);
    exp_err = 1'b0;
    chk("midrst_err", err, exp_err);
    r_never = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req(24'h000034, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("midrst_read", rd, model[6'h0D]);
    chk("midrst_latency", lat, 4);

    rresp_cfg = 2'b10;
    req(24'h000104, 32'h0, 4'h0, 1'b0, rd, lat);
    exp_err = ERR_EN;
    chk("rresp_err", err, exp_err);
    chk("rresp_data", rd, model[6'h01]);
    rresp_cfg = 2'b00;

    na = n_aw;
    nr = n_ar;
    req(24'h000040, 32'hCAFEF00D, 4'hF, 1'b1, rd, lat);
    model_write(24'h000040, 32'hCAFEF00D, 4'hF);
    addr = 24'h000043;
    wstrb = 4'h0;
    @(negedge clk);
    chk("b2b_gap", {axi_awvalid, axi_arvalid}, 2'b00);
    @(negedge clk);
    chk("b2b_issue", {axi_awvalid, axi_arvalid}, 2'b01);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_ready", ready, 1'b1);
    chk("b2b_data", rdata, model[6'h10]);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_aw_count", n_aw - na, 1);
    chk("b2b_ar_count", n_ar - nr, 1);

    for (int t = 0; t < 40; t++) begin
      aw_len = int'($urandom_range(1, 3));
      w_len = int'($urandom_range(1, 3));
      ar_len = int'($urandom_range(1, 3));
      b_gap = int'($urandom_range(0, 2));
      r_gap = int'($urandom_range(0, 2));
      a = ADDR_W'($urandom);
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req(a, d, s, 1'b0, rd, lat);
      if (s != 4'h0) begin
        model_write(a, d, s);
        chk("rnd_awaddr", cap_awaddr, word_of(a));
        chk("rnd_w", {cap_wdata, cap_wstrb}, {d, s});
      end else begin
        chk("rnd_araddr", cap_araddr, word_of(a));
        chk("rnd_rdata", rd, model[a[7:2]]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("rnd_err", err, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
